neuron_weight_sequencer: RTL
============================

// Module: neuron_weight_sequencer
// PURPOSE
//  Sequences one neuron's weighted sum in the fully connected layer. Accepts a stream of numWeight activations,
//  issues one weight-memory read per activation, aligns the read data with the delayed activation, and
//  multiply-accumulates in full precision. It then adds the bias, rescales, saturates to dataWidth, and presents
//  the result to the activation stage over a valid/ready handshake.
// PARAMETERS
//  numWeight     30                      weights (inputs) per neuron; >=1
//  addressWidth  $clog2(numWeight)       weight-memory address width (min 1)
//  dataWidth     16                      signed two's-complement data/weight width
//  fracBits      12                      fractional bits of the fixed-point format (Q3.12 at default)
// PORTS
//  clk        in   1             clock; all state on rising edge
//  rst        in   1             synchronous, active-high reset
//  start      in   1             begin one neuron evaluation (honoured only in IDLE)
//  bias       in   dataWidth     signed bias, same Q format, sampled in the cycle start is accepted
//  in_valid   in   1             activation present
//  in_data    in   dataWidth     signed activation
//  in_ready   out  1             sequencer accepts activation this cycle
//  w_ren      out  1             weight-memory read enable
//  w_radd     out  addressWidth  weight-memory read address
//  w_rdata    in   dataWidth     weight-memory data, valid 1 cycle after w_ren
//  out_valid  out  1             result valid, held until accepted
//  out_data   out  dataWidth     saturated neuron sum
//  out_ready  in   1             downstream accepts result
//  busy       out  1             high in every state except IDLE
// BEHAVIOUR
//  Reset values: in_ready=0, w_ren=0, w_radd=0, out_valid=0, out_data=0, busy=0, acc=0, cnt=0, state=IDLE.
//  FSM states:
//   IDLE  -> RUN on start. Clear acc and cnt, latch bias.
//   RUN   -> DRAIN after the activation with cnt==numWeight-1 is accepted.
//   DRAIN -> BIAS after one cycle, so the last product is accumulated.
//   BIAS  -> OUT after one cycle.
//   OUT   -> IDLE on out_valid&&out_ready.
//  RUN: in_ready=1. Accept when in_valid&&in_ready.
//   On acceptance, w_ren=1 and w_radd=cnt in the same cycle (combinational from cnt).
//   On acceptance, register in_data into x_d with valid bit v_d, then cnt++.
//   in_valid low: no read is issued, cnt holds, and v_d=0 next cycle (bubble).
//  Accumulate: when v_d=1, acc += $signed(w_rdata)*$signed(x_d).
//   Product width 2*dataWidth. acc width 2*dataWidth+$clog2(numWeight)+1; acc never overflows.
//  BIAS stage: sum = (acc + (bias<<<fracBits)) >>> fracBits (arithmetic shift, truncation toward -inf).
//   Saturate sum to [-2^(dataWidth-1), 2^(dataWidth-1)-1], register into out_data, set out_valid.
//  Latency: the result is valid 3 cycles after the last activation is accepted.
//  in_ready=0 outside RUN; in_valid outside RUN is ignored, not queued.
//  OUT: out_valid and out_data stay stable until out_ready; then clear out_valid and return to IDLE.
//  start is ignored while busy. start and acceptance in the same cycle as the OUT->IDLE transition are not merged.
//  numWeight==1: RUN lasts exactly one accepted beat.
//  rst mid-operation: return to IDLE next edge with reset values; any partial sum is discarded.
//  The sequencer never writes the weight memory; weight loading is outside this block.
// STRUCTURE
//  Shared package fnn_pkg:
//   typedef enum logic [2:0] {IDLE,RUN,DRAIN,BIAS,OUT} seq_state_t
//   DATA_W=16, FRAC_BITS=12
//   function sat_trunc() (shift + saturate)
//  One sub-module: neuron_mac_acc (x_d/v_d register, multiplier, accumulator, bias/saturate).
//   It takes clear/enable from the FSM.
//  Top level holds the FSM, cnt, and the handshake logic.
// TESTING (bench uses a 1-cycle-latency memory model with numWeight=30, fracBits=12)
//  1. All weights 0x1000 (1.0), 30 activations 0x0400 (0.25), bias 0:
//     -> out_data=0x7800 (7.5), out_valid 3 cycles after the 30th beat.
//  2. Weights w[i]=i*16, activation 0x1000 only at beat 3 (others 0), bias 0x0100:
//     -> out_data=0x0130; w_radd sequence 0..29.
//  3. Saturation: weights 0x1000, activations 0x1000, bias 0 (sum 30.0) -> out_data=0x7FFF;
//     all weights 0xF000, activations 0x1000 -> out_data=0x8000.
//  4. in_valid toggled 1,0,1,0 and out_ready held low 5 cycles:
//     -> no w_ren on idle beats, result identical to the gapless run;
//     -> out_valid/out_data stable until out_ready.
//  5. rst asserted at beat 10, then a new start with case-2 stimulus:
//     -> all outputs at reset values the cycle after rst, then out_data=0x0130.
//  6. start pulsed during RUN and in_valid driven during IDLE:
//     -> both ignored, cnt unaffected, in_ready=0 in IDLE.

Source files
------------

// File: rtl/fnn_pkg.sv
// rtl/fnn_pkg.sv - shared types, format constants and shift/saturate helper for the FC layer
// Contents: seq_state_t (sequencer FSM states), DATA_W / FRAC_BITS (default Q format),
//           sat_trunc() (arithmetic right shift by frac, then clamp to a signed width-bit range).
package fnn_pkg;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, BIAS, OUT} seq_state_t;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 12;

  // Result is returned 64 bits wide so callers of any data width can cast it down.
  // The arithmetic shift truncates toward -inf.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] v,
                                                   input int unsigned        frac,
                                                   input int unsigned        width);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = v >>> frac;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/neuron_mac_acc.sv
// rtl/neuron_mac_acc.sv - activation register, full-precision MAC, bias add and saturation
// Ports: clk, rst (sync, active high); clear (start of neuron: zero acc, latch bias);
//        bias; in_en/in_data (accepted activation); w_rdata (weight, one cycle after in_en);
//        bias_en (register the biased, rescaled, saturated sum); out_data.
import fnn_pkg::*;

module neuron_mac_acc #(
  parameter int numWeight = 30,
  parameter int dataWidth = DATA_W,
  parameter int fracBits  = FRAC_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [dataWidth-1:0] bias,
  input  logic                 in_en,
  input  logic [dataWidth-1:0] in_data,
  input  logic [dataWidth-1:0] w_rdata,
  input  logic                 bias_en,
  output logic [dataWidth-1:0] out_data
);

  // Headroom of clog2(numWeight)+1 bits keeps the sum of numWeight full products exact.
  localparam int ACC_W  = 2 * dataWidth + $clog2(numWeight) + 1;
  localparam int PROD_W = 2 * dataWidth;

  logic [dataWidth-1:0]     x_q, x_d;
  logic                     v_q, v_d;
  logic [dataWidth-1:0]     bias_q, bias_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [dataWidth-1:0]     out_q, out_d;

  logic signed [PROD_W-1:0] w_ext, x_ext, prod;
  logic signed [ACC_W-1:0]  prod_ext, bias_sh, sum;
  logic signed [63:0]       sum_ext;

  always_comb begin
    // Operands are sign-extended to product width so the multiply is exact and warning-free.
    w_ext    = {{dataWidth{w_rdata[dataWidth-1]}}, w_rdata};
    x_ext    = {{dataWidth{x_q[dataWidth-1]}}, x_q};
    prod     = w_ext * x_ext;
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    bias_sh  = {{(ACC_W-dataWidth){bias_q[dataWidth-1]}}, bias_q};
    bias_sh  = bias_sh <<< fracBits;
    sum      = acc_q + bias_sh;
    sum_ext  = {{(64-ACC_W){sum[ACC_W-1]}}, sum};

    x_d    = x_q;
    v_d    = in_en;
    bias_d = bias_q;
    acc_d  = acc_q;
    out_d  = out_q;

    if (in_en) begin
      x_d = in_data;
    end

    // v_q marks the cycle where w_rdata belongs to the activation held in x_q.
    if (clear) begin
      acc_d  = '0;
      bias_d = bias;
      v_d    = 1'b0;
    end else if (v_q) begin
      acc_d = acc_q + prod_ext;
    end

    if (bias_en) begin
      out_d = dataWidth'(sat_trunc(sum_ext, fracBits, dataWidth));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      v_q    <= 1'b0;
      bias_q <= '0;
      acc_q  <= '0;
      out_q  <= '0;
    end else begin
      x_q    <= x_d;
      v_q    <= v_d;
      bias_q <= bias_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
    end
  end

  assign out_data = out_q;

endmodule

// File: rtl/neuron_weight_sequencer.sv
// rtl/neuron_weight_sequencer.sv - FSM, beat counter and handshakes for one neuron's weighted sum
// Ports: clk, rst (sync, active high); start/bias (begin a neuron, honoured in IDLE);
//        in_valid/in_data/in_ready (activation stream); w_ren/w_radd/w_rdata (weight read,
//        data one cycle after w_ren); out_valid/out_data/out_ready (result); busy (not IDLE).
import fnn_pkg::*;

module neuron_weight_sequencer #(
  parameter int numWeight    = 30,
  parameter int addressWidth = (numWeight > 1) ? $clog2(numWeight) : 1,
  parameter int dataWidth    = DATA_W,
  parameter int fracBits     = FRAC_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [dataWidth-1:0]    bias,
  input  logic                    in_valid,
  input  logic [dataWidth-1:0]    in_data,
  output logic                    in_ready,
  output logic                    w_ren,
  output logic [addressWidth-1:0] w_radd,
  input  logic [dataWidth-1:0]    w_rdata,
  output logic                    out_valid,
  output logic [dataWidth-1:0]    out_data,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam logic [addressWidth-1:0] LAST = addressWidth'(numWeight - 1);

  seq_state_t              state_q, state_d;
  logic [addressWidth-1:0] cnt_q, cnt_d;
  logic                    accept;
  logic                    clear;
  logic                    bias_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    bias_en = 1'b0;
    accept  = (state_q == RUN) && in_valid;

    case (state_q)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + addressWidth'(1);
          end
        end
      end
      // The last weight arrives during DRAIN; BIAS then sees the complete sum.
      DRAIN: state_d = BIAS;
      BIAS: begin
        bias_en = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == RUN);
  assign w_ren     = accept;
  assign w_radd    = cnt_q;
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);

  neuron_mac_acc #(
    .numWeight (numWeight),
    .dataWidth (dataWidth),
    .fracBits  (fracBits)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .bias     (bias),
    .in_en    (accept),
    .in_data  (in_data),
    .w_rdata  (w_rdata),
    .bias_en  (bias_en),
    .out_data (out_data)
  );

endmodule
